// File: rtl/pipelined_control_unit.sv
// RV32I(+M) control decoder with a registered ID/EX control stage.
// Holds one decoded bundle behind a valid/ready handshake and counts illegal instructions.
module pipelined_control_unit #(
    parameter bit HAS_M     = 1'b1,
    parameter int ILL_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          instr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 RegWrite,
    output logic                 MemWrite,
    output logic [1:0]           ResultSrc,
    output logic                 ALUSrcA,
    output logic                 ALUSrcB,
    output logic [2:0]           ImmSrc,
    output logic [4:0]           ALUControl,
    output logic                 Branch,
    output logic                 Jump,
    output logic                 Jalr,
    output logic [2:0]           Funct3,
    output logic                 Illegal,
    output logic [ILL_CNT_W-1:0] ill_count
);

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic [1:0] result_src;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [2:0] imm_src;
        logic [4:0] alu_control;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic [2:0] funct3;
        logic       illegal;
    } ctrl_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [4:0] ALU_ADD   = 5'b00000;
    localparam logic [4:0] ALU_SUB   = 5'b00001;
    localparam logic [4:0] ALU_SLL   = 5'b00010;
    localparam logic [4:0] ALU_SLT   = 5'b00011;
    localparam logic [4:0] ALU_SLTU  = 5'b00100;
    localparam logic [4:0] ALU_XOR   = 5'b00101;
    localparam logic [4:0] ALU_SRL   = 5'b00110;
    localparam logic [4:0] ALU_SRA   = 5'b00111;
    localparam logic [4:0] ALU_OR    = 5'b01000;
    localparam logic [4:0] ALU_AND   = 5'b01001;
    localparam logic [4:0] ALU_PASSB = 5'b01010;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    function automatic logic [4:0] alu_base(input logic [2:0] f3);
        case (f3)
            3'b000:  alu_base = ALU_ADD;
            3'b001:  alu_base = ALU_SLL;
            3'b010:  alu_base = ALU_SLT;
            3'b011:  alu_base = ALU_SLTU;
            3'b100:  alu_base = ALU_XOR;
            3'b101:  alu_base = ALU_SRL;
            3'b110:  alu_base = ALU_OR;
            default: alu_base = ALU_AND;
        endcase
    endfunction

    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ill;
    ctrl_t      dec;
    logic       unused_imm_bits;

    assign op = instr[6:0];
    assign f3 = instr[14:12];
    assign f7 = instr[31:25];
    assign unused_imm_bits = ^{instr[24:15], instr[11:7]};

    always_comb begin
        dec        = '0;
        dec.funct3 = f3;
        ill        = 1'b0;
        case (op)
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.result_src = 2'b01;
                dec.alu_src_b  = 1'b1;
                ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OP_STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_src_b = 1'b1;
                dec.imm_src   = 3'b001;
                ill = f3[2] || (f3 == 3'b011);
            end
            OP_R: begin
                dec.reg_write = 1'b1;
                if (f7 == F7_BASE)                    dec.alu_control = alu_base(f3);
                else if (f7 == F7_ALT && f3 == 3'b000) dec.alu_control = ALU_SUB;
                else if (f7 == F7_ALT && f3 == 3'b101) dec.alu_control = ALU_SRA;
                else if (f7 == F7_MUL && HAS_M)        dec.alu_control = {2'b10, f3};
                else                                   ill = 1'b1;
            end
            OP_I: begin
                dec.reg_write   = 1'b1;
                dec.alu_src_b   = 1'b1;
                dec.alu_control = alu_base(f3);
                // Shift-immediates reuse instr[31:25] as funct7; only SRAI may set bit 30.
                if (f3 == 3'b001) ill = (f7 != F7_BASE);
                if (f3 == 3'b101) begin
                    if (f7 == F7_ALT)        dec.alu_control = ALU_SRA;
                    else if (f7 != F7_BASE)  ill = 1'b1;
                end
            end
            OP_BRANCH: begin
                dec.branch      = 1'b1;
                dec.alu_control = ALU_SUB;
                dec.imm_src     = 3'b010;
                ill = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OP_LUI: begin
                dec.reg_write   = 1'b1;
                dec.alu_src_b   = 1'b1;
                dec.imm_src     = 3'b011;
                dec.alu_control = ALU_PASSB;
            end
            OP_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.alu_src_a = 1'b1;
                dec.alu_src_b = 1'b1;
                dec.imm_src   = 3'b011;
            end
            OP_JAL: begin
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.result_src = 2'b10;
                dec.imm_src    = 3'b100;
            end
            OP_JALR: begin
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.jalr       = 1'b1;
                dec.result_src = 2'b10;
                dec.alu_src_b  = 1'b1;
                ill = (f3 != 3'b000);
            end
            default: ill = 1'b1;
        endcase
        // An illegal word must never cause architectural side effects downstream.
        if (ill) begin
            dec         = '0;
            dec.funct3  = f3;
            dec.illegal = 1'b1;
        end
    end

    // Handshake: a word transfers on in_valid && in_ready unless flush kills it.
    logic                 out_valid_q, out_valid_d;
    ctrl_t                bundle_q, bundle_d;
    logic [ILL_CNT_W-1:0] ill_count_q, ill_count_d;
    logic                 accept;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        out_valid_d = out_valid_q;
        bundle_d    = bundle_q;
        ill_count_d = ill_count_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            bundle_d    = dec;
            if (dec.illegal && (ill_count_q != {ILL_CNT_W{1'b1}}))
                ill_count_d = ill_count_q + {{(ILL_CNT_W-1){1'b0}}, 1'b1};
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
            ill_count_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            bundle_q    <= bundle_d;
            ill_count_q <= ill_count_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign RegWrite   = bundle_q.reg_write;
    assign MemWrite   = bundle_q.mem_write;
    assign ResultSrc  = bundle_q.result_src;
    assign ALUSrcA    = bundle_q.alu_src_a;
    assign ALUSrcB    = bundle_q.alu_src_b;
    assign ImmSrc     = bundle_q.imm_src;
    assign ALUControl = bundle_q.alu_control;
    assign Branch     = bundle_q.branch;
    assign Jump       = bundle_q.jump;
    assign Jalr       = bundle_q.jalr;
    assign Funct3     = bundle_q.funct3;
    assign Illegal    = bundle_q.illegal;
    assign ill_count  = ill_count_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: three instances (M on, M off, 2-bit counter) share
// one stimulus stream and are compared each cycle against a decode model built from tables.
module tb_pipelined_control_unit;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic [1:0] result_src;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [2:0] imm_src;
        logic [4:0] alu_control;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic [2:0] funct3;
        logic       illegal;
    } exp_t;

    // ---------------- clock / reset / shared inputs ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    always #5 clk = ~clk;

    logic        ov [3];
    logic        ir [3];
    logic [15:0] cnt_arr [3];
    exp_t        bun [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = (g == 2) ? 2 : 16;
        logic [W-1:0] cnt;
        logic         rw, mw, asa, asb, br, jp, jr, il, ov_l, ir_l;
        logic [1:0]   rs;
        logic [2:0]   is, f3o;
        logic [4:0]   ac;
        pipelined_control_unit #(.HAS_M((g == 1) ? 1'b0 : 1'b1), .ILL_CNT_W(W)) u_dut (
            .clk(clk), .rst_n(rst_n), .instr(instr), .in_valid(in_valid),
            .in_ready(ir_l), .flush(flush), .out_valid(ov_l), .out_ready(out_ready),
            .RegWrite(rw), .MemWrite(mw), .ResultSrc(rs), .ALUSrcA(asa), .ALUSrcB(asb),
            .ImmSrc(is), .ALUControl(ac), .Branch(br), .Jump(jp), .Jalr(jr),
            .Funct3(f3o), .Illegal(il), .ill_count(cnt)
        );
        assign ov[g]      = ov_l;
        assign ir[g]      = ir_l;
        assign cnt_arr[g] = 16'(cnt);
        assign bun[g]     = {rw, mw, rs, asa, asb, is, ac, br, jp, jr, f3o, il};
    end

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic exp_t model_dec(input logic [31:0] w, input bit has_m);
        exp_t        e;
        logic [2:0]  f3 = w[14:12];
        logic [6:0]  f7 = w[31:25];
        logic [39:0] base = {5'd9, 5'd8, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd0};
        logic [7:0]  load_ok = 8'b0011_0111;
        logic [7:0]  store_ok = 8'b0000_0111;
        logic [7:0]  branch_ok = 8'b1111_0011;
        bit          ok = 1'b1;
        e = '0;
        e.funct3 = f3;
        case (w[6:0])
            7'h03: begin e.reg_write = 1; e.result_src = 1; e.alu_src_b = 1; ok = load_ok[f3]; end
            7'h23: begin e.mem_write = 1; e.alu_src_b = 1; e.imm_src = 1; ok = store_ok[f3]; end
            7'h33: begin
                e.reg_write = 1;
                if (f7 == 7'h00)                 e.alu_control = base[f3*5 +: 5];
                else if (f7 == 7'h20 && f3 == 0) e.alu_control = 5'd1;
                else if (f7 == 7'h20 && f3 == 5) e.alu_control = 5'd7;
                else if (f7 == 7'h01 && has_m)   e.alu_control = 5'd16 + 5'(f3);
                else                             ok = 0;
            end
            7'h13: begin
                e.reg_write = 1; e.alu_src_b = 1;
                e.alu_control = base[f3*5 +: 5];
                if (f3 == 1) ok = (f7 == 7'h00);
                if (f3 == 5) begin
                    ok = (f7 == 7'h00) || (f7 == 7'h20);
                    e.alu_control = (f7 == 7'h20) ? 5'd7 : 5'd6;
                end
            end
            7'h63: begin e.branch = 1; e.alu_control = 5'd1; e.imm_src = 2; ok = branch_ok[f3]; end
            7'h37: begin e.reg_write = 1; e.alu_src_b = 1; e.imm_src = 3; e.alu_control = 5'd10; end
            7'h17: begin e.reg_write = 1; e.alu_src_a = 1; e.alu_src_b = 1; e.imm_src = 3; end
            7'h6F: begin e.reg_write = 1; e.jump = 1; e.result_src = 2; e.imm_src = 4; end
            7'h67: begin
                e.reg_write = 1; e.jump = 1; e.jalr = 1; e.result_src = 2; e.alu_src_b = 1;
                ok = (f3 == 0);
            end
            default: ok = 0;
        endcase
        if (!ok) begin
            e = '0;
            e.funct3 = f3;
            e.illegal = 1;
        end
        return e;
    endfunction

    bit   mv [3];
    exp_t mb [3];
    int   mc [3];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                mv[i] = 0; mb[i] = '0; mc[i] = 0;
            end else if (flush) begin
                mv[i] = 0;
            end else if (in_valid && (!mv[i] || out_ready)) begin
                mv[i] = 1;
                mb[i] = model_dec(instr, i != 1);
                if (mb[i].illegal && mc[i] < ((i == 2) ? 3 : 65535)) mc[i]++;
            end else if (out_ready) begin
                mv[i] = 0;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (check_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("u%0d_out_valid", i), 32'(ov[i]), 32'(mv[i]));
                chk($sformatf("u%0d_in_ready", i), 32'(ir[i]), 32'(!mv[i] || out_ready));
                chk($sformatf("u%0d_ill_count", i), 32'(cnt_arr[i]), 32'(mc[i]));
                if (mv[i]) begin
                    if (mb[i].illegal)
                        chk($sformatf("u%0d_illegal_bundle", i),
                            32'({bun[i].illegal, bun[i].reg_write, bun[i].mem_write, bun[i].branch, bun[i].jump}),
                            32'({mb[i].illegal, mb[i].reg_write, mb[i].mem_write, mb[i].branch, mb[i].jump}));
                    else
                        chk($sformatf("u%0d_bundle", i), 32'(bun[i]), 32'(mb[i]));
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic rand_instr(output logic [31:0] w);
        logic [6:0]  ops [10] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h00};
        logic [6:0]  f7s [4] = '{7'h00, 7'h20, 7'h01, 7'h00};
        logic [31:0] r = $urandom;
        logic [6:0]  op = ops[$urandom_range(0, 9)];
        logic [6:0]  f7 = f7s[$urandom_range(0, 3)];
        if (op == 7'h00) op = 7'($urandom);
        if ($urandom_range(0, 7) == 0) f7 = 7'($urandom);
        w = {f7, r[24:15], 3'($urandom_range(0, 7)), r[11:7], op};
    endtask

    initial begin
        logic [31:0] w;
        rst_n = 0;
        step(); step();
        rst_n = 1;
        check_en = 1;
        chk("rst_out_valid", 32'(ov[0]), 32'h0);
        chk("rst_regwrite", 32'(bun[0].reg_write), 32'h0);
        chk("rst_alucontrol", 32'(bun[0].alu_control), 32'h0);
        chk("rst_ill_count", 32'(cnt_arr[0]), 32'h0);
        chk("rst_in_ready", 32'(ir[0]), 32'h1);

        instr = 32'h002081B3; in_valid = 1; out_ready = 1;
        step();
        chk("add_valid", 32'(ov[0]), 32'h1);
        chk("add_regwrite", 32'(bun[0].reg_write), 32'h1);
        chk("add_alu", 32'(bun[0].alu_control), 32'h00);
        chk("add_srcb", 32'(bun[0].alu_src_b), 32'h0);
        chk("add_result", 32'(bun[0].result_src), 32'h0);

        instr = 32'h402081B3;
        step();
        chk("sub_alu", 32'(bun[0].alu_control), 32'h01);
        instr = 32'h0080A283;
        step();
        chk("lw_valid", 32'(ov[0]), 32'h1);
        chk("lw_result", 32'(bun[0].result_src), 32'h1);
        chk("lw_srcb", 32'(bun[0].alu_src_b), 32'h1);
        chk("lw_imm", 32'(bun[0].imm_src), 32'h0);
        chk("lw_funct3", 32'(bun[0].funct3), 32'h2);

        instr = 32'h022081B3;
        step();
        chk("mul_alu", 32'(bun[0].alu_control), 32'h10);
        chk("mul_legal", 32'(bun[0].illegal), 32'h0);
        chk("mul_nom_illegal", 32'(bun[1].illegal), 32'h1);
        chk("mul_nom_regwrite", 32'(bun[1].reg_write), 32'h0);
        chk("mul_nom_count", 32'(cnt_arr[1]), 32'h1);

        instr = 32'h008000EF;
        step();
        out_ready = 0; instr = 32'h002081B3;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_in_ready", 32'(ir[0]), 32'h0);
            chk("stall_jal", 32'({bun[0].jump, bun[0].result_src, bun[0].imm_src, ov[0]}), 32'b1_10_100_1);
        end
        out_ready = 1;
        #1;
        chk("release_in_ready", 32'(ir[0]), 32'h1);
        step();
        chk("release_next", 32'({ov[0], bun[0].jump, bun[0].reg_write}), 32'b101);

        instr = 32'hFFFFFFFF; flush = 1;
        step();
        flush = 0;
        chk("flush_valid", 32'(ov[0]), 32'h0);
        chk("flush_count", 32'(cnt_arr[1]), 32'h1);

        instr = 32'h008000EF;
        step();
        out_ready = 0; instr = 32'h002081B3;
        step(); step();
        rst_n = 0;
        step();
        chk("stallrst_valid", 32'(ov[1]), 32'h0);
        chk("stallrst_bundle", 32'(bun[1]), 32'h0);
        chk("stallrst_count", 32'(cnt_arr[1]), 32'h0);
        rst_n = 1;

        instr = 32'hFFFFFFFF; out_ready = 1; in_valid = 1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("sat_count", 32'(cnt_arr[2]), 32'((k < 3) ? k + 1 : 3));
        end

        for (int n = 0; n < 3000; n++) begin
            rand_instr(w);
            instr     = w;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            rst_n     = ($urandom_range(0, 299) != 0);
            step();
        end
        rst_n = 1; flush = 0; in_valid = 0;
        step();
        check_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
